// File: rtl/mem_stage_unit.sv
// mem_stage_unit: MEM pipeline stage. Resolves control flow from the EX/MEM fields, runs the
// data-memory req/gnt/rvalid handshake with a timeout, stalls upstream while an access is
// outstanding and registers the MEM/WB writeback.
`timescale 1ns / 1ps

module mem_stage_unit #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rs2,
    input  logic [31:0] immPc,
    input  logic [31:0] pcAdd4,
    input  logic [31:0] outAlu,
    input  logic [31:0] imm,
    input  logic [4:0]  rd,
    input  logic        EscReg,
    input  logic        EscMem,
    input  logic        lw,
    input  logic        jump,
    input  logic        jalr,
    input  logic        blt,
    input  logic        bge,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mem_err
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitR} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_err_q, mem_err_d;
    logic               wb_we_q, wb_we_d;
    logic [4:0]         wb_rd_q, wb_rd_d;
    logic [31:0]        wb_data_q, wb_data_d;

    logic               mem_op, is_load, timeout_hit, taken;
    logic [31:0]        load_data;

    // A store takes precedence when both lw and EscMem are set.
    assign mem_op      = lw | EscMem;
    assign is_load     = lw & ~EscMem;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    assign dmem_we    = EscMem;
    assign dmem_addr  = outAlu;
    assign dmem_wdata = rs2;

    // Branch resolution; the redirect is suppressed while the stage is stalled.
    always_comb begin
        taken       = jump | jalr | (blt & outAlu[0]) | (bge & ~outAlu[0]);
        redirect_pc = jalr ? {outAlu[31:1], 1'b0} : immPc;
        redirect_o  = taken & ~stall_o;
        flush_o     = taken & ~stall_o;
    end

    // Memory handshake FSM and timeout counter next-state; stall_o drops in the completing cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = mem_err_q;
        dmem_req  = 1'b0;
        stall_o   = 1'b0;
        load_data = 32'h0;
        case (state_q)
            StIdle: begin
                if (mem_op) begin
                    dmem_req = 1'b1;
                    if (dmem_gnt) begin
                        if (is_load) begin
                            if (dmem_rvalid) begin
                                load_data = dmem_rdata;
                            end else begin
                                state_d = StWaitR;
                                cnt_d   = '0;
                                stall_o = 1'b1;
                            end
                        end
                    end else begin
                        state_d = StReq;
                        cnt_d   = '0;
                        stall_o = 1'b1;
                    end
                end
            end
            StReq: begin
                dmem_req = 1'b1;
                if (dmem_gnt) begin
                    if (!is_load) begin
                        state_d = StIdle;
                    end else if (dmem_rvalid) begin
                        load_data = dmem_rdata;
                        state_d   = StIdle;
                    end else begin
                        state_d = StWaitR;
                        cnt_d   = '0;
                        stall_o = 1'b1;
                    end
                end else if (timeout_hit) begin
                    // Abort: release the pipeline with zero load data and flag the error.
                    mem_err_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    stall_o = 1'b1;
                end
            end
            StWaitR: begin
                if (dmem_rvalid) begin
                    load_data = dmem_rdata;
                    state_d   = StIdle;
                end else if (timeout_hit) begin
                    mem_err_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    stall_o = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Writeback next-state: wb_we is squashed while stalled, rd/data hold.
    always_comb begin
        wb_we_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (!stall_o) begin
            wb_we_d = EscReg & (rd != 5'd0);
            wb_rd_d = rd;
            if (is_load) begin
                wb_data_d = load_data;
            end else if (jump | jalr) begin
                wb_data_d = pcAdd4;
            end else if (!EscReg && !lw) begin
                // Nothing is written back here, so imm is carried through for observation.
                wb_data_d = imm;
            end else begin
                wb_data_d = outAlu;
            end
        end
    end

    // State, counter, sticky error and MEM/WB registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= 5'd0;
            wb_data_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
            wb_we_q   <= wb_we_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_we   = wb_we_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;
    assign mem_err = mem_err_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// tb_mem_stage_unit: directed vectors with a scoreboard. Stimulus pushes expected writebacks
// and redirect targets; monitors pop and compare whenever the DUT presents them.
`timescale 1ns / 1ps

module tb_mem_stage_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rs2, immPc, pcAdd4, outAlu, imm;
    logic [4:0]  rd;
    logic        EscReg, EscMem, lw, jump, jalr, blt, bge;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_o, flush_o, redirect_o;
    logic [31:0] redirect_pc;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_err;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t         exp_wb[$];
    logic [31:0] exp_pc[$];
    wb_t         cur_wb;
    logic [31:0] cur_pc;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          stalls;
    logic        released;

    always #5 clk = ~clk;

    mem_stage_unit #(.TIMEOUT(64), .CNT_W(7)) dut (
        .clk         (clk),
        .reset       (reset),
        .rs2         (rs2),
        .immPc       (immPc),
        .pcAdd4      (pcAdd4),
        .outAlu      (outAlu),
        .imm         (imm),
        .rd          (rd),
        .EscReg      (EscReg),
        .EscMem      (EscMem),
        .lw          (lw),
        .jump        (jump),
        .jalr        (jalr),
        .blt         (blt),
        .bge         (bge),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .stall_o     (stall_o),
        .flush_o     (flush_o),
        .redirect_o  (redirect_o),
        .redirect_pc (redirect_pc),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .mem_err     (mem_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr();
        rs2 = 0; immPc = 0; pcAdd4 = 0; outAlu = 0; imm = 0; rd = 0;
        EscReg = 0; EscMem = 0; lw = 0; jump = 0; jalr = 0; blt = 0; bge = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wb(input logic [4:0] r, input logic [31:0] d);
        exp_wb.push_back({r, d});
    endtask

    // Monitor: every presented writeback / redirect must match the head of its queue.
    always @(negedge clk) begin
        if (!reset && wb_we) begin
            if (exp_wb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wb_unexpected: got rd=%0d data=0x%0h, required no writeback",
                         wb_rd, wb_data);
            end else begin
                cur_wb = exp_wb.pop_front();
                check("wb_rd", {27'd0, wb_rd}, {27'd0, cur_wb.rd});
                check("wb_data", wb_data, cur_wb.data);
            end
        end
        if (!reset && redirect_o) begin
            if (exp_pc.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL redirect_unexpected: got pc=0x%0h, required no redirect",
                         redirect_pc);
            end else begin
                cur_pc = exp_pc.pop_front();
                check("redirect_pc", redirect_pc, cur_pc);
                check("flush_with_redirect", {31'd0, flush_o}, 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clr();
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, dmem_req}, 0);
        check("rst_stall", {31'd0, stall_o}, 0);
        check("rst_wb_we", {31'd0, wb_we}, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_mem_err", {31'd0, mem_err}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Store granted in the issue cycle: no stall.
        clr(); EscMem = 1; outAlu = 32'h100; rs2 = 32'hDEADBEEF; dmem_gnt = 1;
        @(negedge clk);
        check("st_req", {31'd0, dmem_req}, 1);
        check("st_we", {31'd0, dmem_we}, 1);
        check("st_addr", dmem_addr, 32'h100);
        check("st_wdata", dmem_wdata, 32'hDEADBEEF);
        check("st_stall", {31'd0, stall_o}, 0);

        // Load: gnt in cycle 2, rvalid in cycle 5 -> stalled in cycles 0..4.
        next(); clr(); lw = 1; EscReg = 1; rd = 5; outAlu = 32'h200;
        push_wb(5'd5, 32'h1234);
        stalls = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) next();
            dmem_gnt    = (c == 2);
            dmem_rvalid = (c == 5);
            dmem_rdata  = (c == 5) ? 32'h1234 : 32'hFFFF_FFFF;
            @(negedge clk);
            if (stall_o) stalls++;
            if (c == 3) check("ld_req_dropped_in_wait", {31'd0, dmem_req}, 0);
        end
        check("ld_stall_cycles", stalls, 5);

        // blt taken (outAlu[0]=1).
        next(); clr(); blt = 1; outAlu = 32'h1; immPc = 32'h80;
        exp_pc.push_back(32'h80);
        @(negedge clk);
        check("blt_flush", {31'd0, flush_o}, 1);

        // bge with the same compare result: not taken.
        next(); clr(); bge = 1; outAlu = 32'h1; immPc = 32'h80;
        @(negedge clk);
        check("bge_nt_redirect", {31'd0, redirect_o}, 0);
        check("bge_nt_flush", {31'd0, flush_o}, 0);

        // bge taken (outAlu[0]=0).
        next(); clr(); bge = 1; outAlu = 32'h0; immPc = 32'h90;
        exp_pc.push_back(32'h90);
        @(negedge clk);

        // jal: target immPc, link pcAdd4.
        next(); clr(); jump = 1; immPc = 32'hC0; pcAdd4 = 32'h10; rd = 3; EscReg = 1;
        outAlu = 32'h555;
        exp_pc.push_back(32'hC0);
        push_wb(5'd3, 32'h10);
        @(negedge clk);

        // jalr: LSB of the target cleared, wins over immPc.
        next(); clr(); jalr = 1; outAlu = 32'h203; pcAdd4 = 32'h44; rd = 1; EscReg = 1;
        immPc = 32'h999;
        exp_pc.push_back(32'h202);
        push_wb(5'd1, 32'h44);
        @(negedge clk);

        // Plain ALU writeback.
        next(); clr(); EscReg = 1; rd = 7; outAlu = 32'h55;
        push_wb(5'd7, 32'h55);
        @(negedge clk);

        // Bubble with rd=0: no writeback.
        next(); clr(); EscReg = 1; rd = 0; outAlu = 32'h77;
        next(); clr();
        @(negedge clk);
        check("bubble_wb_we", {31'd0, wb_we}, 0);

        // Load never granted: issue cycle + 63 waiting cycles stalled, then abort.
        next(); clr(); lw = 1; EscReg = 1; rd = 9; outAlu = 32'h300;
        push_wb(5'd9, 32'h0);
        @(negedge clk);
        check("to_issue_stall", {31'd0, stall_o}, 1);
        stalls = 0;
        released = 0;
        for (int i = 0; i < 200; i++) begin
            next();
            @(negedge clk);
            if (!stall_o) begin
                released = 1;
                break;
            end
            stalls++;
        end
        check("to_released", {31'd0, released}, 1);
        check("to_wait_cycles", stalls, 63);
        check("to_err_not_yet", {31'd0, mem_err}, 0);
        next(); clr();
        @(negedge clk);
        check("to_err_set", {31'd0, mem_err}, 1);
        next();
        @(negedge clk);
        check("to_err_sticky", {31'd0, mem_err}, 1);

        // Reset while waiting for rvalid; a late rvalid must be ignored.
        next(); clr(); lw = 1; EscReg = 1; rd = 4; outAlu = 32'h400; dmem_gnt = 1;
        @(negedge clk);
        check("rw_issue_stall", {31'd0, stall_o}, 1);
        next(); dmem_gnt = 0;
        @(negedge clk);
        check("rw_wait_stall", {31'd0, stall_o}, 1);
        #1 reset = 1'b1;
        clr();
        #1;
        check("rw_rst_req", {31'd0, dmem_req}, 0);
        check("rw_rst_stall", {31'd0, stall_o}, 0);
        check("rw_rst_wb_we", {31'd0, wb_we}, 0);
        check("rw_rst_mem_err", {31'd0, mem_err}, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        dmem_rvalid = 1; dmem_rdata = 32'hBAD;
        @(negedge clk);
        check("rw_late_stall", {31'd0, stall_o}, 0);
        check("rw_late_req", {31'd0, dmem_req}, 0);
        next(); clr();
        @(negedge clk);
        check("rw_late_wb_we", {31'd0, wb_we}, 0);

        repeat (3) @(negedge clk);
        check("wb_queue_drained", exp_wb.size(), 0);
        check("pc_queue_drained", exp_pc.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
